series_accumulator: RTL and testbench
=====================================

Name: series_accumulator

Overview:
- Parametrised successor to the fixed 11-state sum controller.
- Computes the arithmetic-series sum w = sum over i=0..n-1 of (first + i*stride) under a start/done handshake.
- Term count, first term and stride are run-time inputs; width is a parameter; overflow is reported.
- Sits as a self-contained FSM-plus-datapath practice block, driven by a bench or an upstream controller.

Parameters:
- WIDTH, 16, width of first, stride, the term register b and result w.
- CNT_W, 8, width of the term count n and the internal term counter.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low, released synchronously to clk.
- start  input  1  request a run; sampled only in IDLE.
- n  input  CNT_W  number of terms; sampled when start is accepted.
- first  input  WIDTH  first term; sampled when start is accepted.
- stride  input  WIDTH  term increment; sampled when start is accepted.
- busy  output  1  high in INIT and ACCUM.
- done  output  1  one-cycle pulse in DONE.
- w  output  WIDTH  accumulated result; holds after done until the next accepted start.
- overflow  output  1  sticky per run; set if any addition to w or b carried out of WIDTH bits.

Behaviour:
- Reset (reset low) sets state=IDLE, w=0, b=0, term counter=0, busy=0, done=0 and overflow=0, asynchronously.
- States: IDLE, INIT, ACCUM, DONE.
- IDLE:
  - start=1 latches n, first and stride, then moves to INIT. Latching n and first together with b=first and counter=0 is acceptable.
  - start=0 stays in IDLE; w and overflow hold.
- INIT (1 cycle):
  - b<=first, w<=0, counter<=0, overflow<=0.
  - Next state is ACCUM if latched n!=0, else DONE.
- ACCUM (exactly n cycles):
  - Each cycle: w<=w+b, b<=b+stride, counter<=counter+1.
  - Leave for DONE on the cycle where counter==n-1, after performing that final add.
- DONE (1 cycle): done=1, then back to IDLE unconditionally.
- Latency: start sampled at edge E0 gives INIT after E0, ACCUM after E1, and DONE after E(n+1); done is high for one cycle. For n=0, DONE follows E1.
- Arithmetic:
  - All sums are modulo 2^WIDTH.
  - overflow<=1 if the carry out of w+b, or out of b+stride, is set on any add in ACCUM.
  - A b-carry on the final ACCUM cycle also counts.
- start while busy or in DONE is ignored; there is no queueing.
- Inputs n, first and stride may change freely after acceptance; only the latched copies are used.
- A reset assertion mid-run aborts immediately to the reset values; no done pulse is issued.
- n at its maximum (2^CNT_W-1) must work: the counter must not wrap before the terminal compare.

Decomposition:
- Shared package series_pkg holds the state typedef (enum of IDLE, INIT, ACCUM, DONE, 2-bit logic).
- One natural sub-module: series_datapath, containing the b, w and counter registers, the two adders and the carry-to-overflow logic.
- series_datapath is controlled by an init strobe and an acc strobe from the FSM in series_accumulator, and returns a last_term flag.

Test Plan:
- WIDTH=16, n=10, first=1, stride=1, start pulse -> busy for 11 cycles, done pulse after E11, w=55, overflow=0.
- n=5, first=1, stride=2 -> w=25 (1+3+5+7+9); n=4, first=100, stride=0xFFFF (−1) -> w=394, overflow=1 from the b adder.
- n=0, first=7 -> INIT then DONE, done pulse after E1, w=0, overflow=0.
- WIDTH=6, n=11, first=1, stride=1 -> w=66 mod 64=2, overflow=1; a following run with n=3, first=1, stride=1 gives w=6 and clears overflow to 0.
- start re-asserted with n=2 during the busy cycles of an n=10 run -> ignored, result 55, a single done pulse.
- reset driven low mid-ACCUM, asynchronously between edges -> w, busy and overflow read 0 before the next clk edge, state is IDLE, no done pulse; a subsequent start completes correctly.

Source files
------------

// File: rtl/series_pkg.sv
// series_pkg: types shared by the series accumulator slice.
//   state_t : controller state encoding (IDLE, INIT, ACCUM, DONE).
package series_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/series_datapath.sv
// series_datapath: term register b, result register w, term counter and
// sticky overflow for the arithmetic-series accumulator.
//   clk       : clock, all state on rising edge
//   reset     : asynchronous active-low reset
//   init      : load b from first, clear w, counter and overflow
//   acc       : perform one accumulation step (w+=b, b+=stride, cnt++)
//   first     : latched first term
//   stride    : latched term increment
//   n         : latched term count
//   w         : accumulated result
//   overflow  : sticky carry-out flag for the current run
//   last_term : counter has reached n-1 (final accumulation step)
module series_datapath
    import series_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             acc,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] stride,
    input  logic [CNT_W-1:0] n,
    output logic [WIDTH-1:0] w,
    output logic             overflow,
    output logic             last_term
);

    logic [WIDTH-1:0] b;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   b_sum;

    // One extra bit on each adder exposes the carry out of WIDTH bits.
    always_comb begin
        w_sum = {1'b0, w} + {1'b0, b};
        b_sum = {1'b0, b} + {1'b0, stride};
    end

    // Terminal compare against n-1 so that the counter never has to reach n;
    // n = 2^CNT_W-1 therefore completes without the counter wrapping.
    always_comb begin
        last_term = (cnt == (n - CNT_W'(1)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b        <= '0;
            w        <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (init) begin
            b        <= first;
            w        <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (acc) begin
            w        <= w_sum[WIDTH-1:0];
            b        <= b_sum[WIDTH-1:0];
            cnt      <= cnt + CNT_W'(1);
            overflow <= overflow | w_sum[WIDTH] | b_sum[WIDTH];
        end
    end

endmodule

// File: rtl/series_accumulator.sv
// series_accumulator: computes w = sum_{i=0}^{n-1} (first + i*stride)
// modulo 2^WIDTH under a start/done handshake.
//   clk      : clock, all state on rising edge
//   reset    : asynchronous active-low reset
//   start    : run request, accepted only in IDLE
//   n        : number of terms (latched on accept)
//   first    : first term (latched on accept)
//   stride   : term increment (latched on accept)
//   busy     : high while in INIT or ACCUM
//   done     : one-cycle completion pulse
//   w        : result, held until the next accepted start
//   overflow : sticky carry-out of either adder during the run
module series_accumulator
    import series_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] stride,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] w,
    output logic             overflow
);

    state_t           state;
    logic [CNT_W-1:0] n_q;
    logic [WIDTH-1:0] first_q;
    logic [WIDTH-1:0] stride_q;
    logic             init_stb;
    logic             acc_stb;
    logic             last_term;

    always_comb begin
        init_stb = (state == INIT);
        acc_stb  = (state == ACCUM);
    end

    // busy and done are registered alongside the state so they change
    // exactly on the state transitions that define them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            n_q      <= '0;
            first_q  <= '0;
            stride_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q      <= n;
                        first_q  <= first;
                        stride_q <= stride;
                        busy     <= 1'b1;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    if (n_q != '0) begin
                        state <= ACCUM;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                ACCUM: begin
                    if (last_term) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    series_datapath #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .init      (init_stb),
        .acc       (acc_stb),
        .first     (first_q),
        .stride    (stride_q),
        .n         (n_q),
        .w         (w),
        .overflow  (overflow),
        .last_term (last_term)
    );

endmodule

// File: tb/tb_series_accumulator.sv
module tb_series_accumulator;

    typedef struct {
        logic [15:0] w;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    // 16-bit instance
    logic        start16 = 1'b0;
    logic [7:0]  n16 = '0;
    logic [15:0] first16 = '0;
    logic [15:0] stride16 = '0;
    logic        busy16, done16, ovf16;
    logic [15:0] w16;

    // 6-bit instance
    logic        start6 = 1'b0;
    logic [7:0]  n6 = '0;
    logic [5:0]  first6 = '0;
    logic [5:0]  stride6 = '0;
    logic        busy6, done6, ovf6;
    logic [5:0]  w6;

    int errors = 0;
    int checks = 0;
    int done16_cnt = 0;
    int done6_cnt = 0;
    exp_t q16[$];
    exp_t q6[$];

    always #5 clk = ~clk;

    series_accumulator #(.WIDTH(16), .CNT_W(8)) dut16 (
        .clk(clk), .reset(reset_n), .start(start16), .n(n16),
        .first(first16), .stride(stride16), .busy(busy16), .done(done16),
        .w(w16), .overflow(ovf16)
    );

    series_accumulator #(.WIDTH(6), .CNT_W(8)) dut6 (
        .clk(clk), .reset(reset_n), .start(start6), .n(n6),
        .first(first6), .stride(stride6), .busy(busy6), .done(done6),
        .w(w6), .overflow(ovf6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare whenever a done pulse is presented.
    always @(negedge clk) begin
        if (reset_n && done16 === 1'b1) begin
            exp_t e;
            done16_cnt++;
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done16: got done=1 expected no pending run");
            end else begin
                e = q16.pop_front();
                check("w16", 32'(w16), 32'(e.w));
                check("ovf16", 32'(ovf16), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && done6 === 1'b1) begin
            exp_t e;
            done6_cnt++;
            if (q6.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done6: got done=1 expected no pending run");
            end else begin
                e = q6.pop_front();
                check("w6", 32'(w6), 32'(e.w));
                check("ovf6", 32'(ovf6), 32'(e.ovf));
            end
        end
    end

    // Issue one run on the 16-bit instance. poke re-asserts start (n=2)
    // while busy and again during the DONE cycle; both must be ignored.
    task automatic run16(input logic [7:0] nn, input logic [15:0] f, input logic [15:0] s,
                         input logic [15:0] ew, input logic eo, input bit poke);
        exp_t e;
        int k;
        int busy_cnt;
        int d0;
        @(negedge clk);
        n16 = nn; first16 = f; stride16 = s; start16 = 1'b1;
        e.w = ew; e.ovf = eo;
        q16.push_back(e);
        d0 = done16_cnt;
        @(negedge clk);
        start16 = 1'b0;
        // scramble the live inputs: only latched copies may be used
        n16 = 8'd2; first16 = 16'hABCD; stride16 = 16'h1357;
        k = 0;
        busy_cnt = 0;
        while (done16 !== 1'b1 && k < 400) begin
            if (busy16 === 1'b1) busy_cnt++;
            if (poke) start16 = (k >= 1 && k <= 3);
            @(negedge clk);
            k++;
        end
        start16 = 1'b0;
        check("done_latency16", 32'(k), 32'(nn) + 32'd1);
        check("busy_cycles16", 32'(busy_cnt), 32'(nn) + 32'd1);
        if (poke) start16 = 1'b1;   // high through the DONE->IDLE edge
        @(negedge clk);
        start16 = 1'b0;
        check("done_pulse_width16", 32'(done16), 32'd0);
        check("idle_after_done16", 32'(busy16), 32'd0);
        check("done_count16", 32'(done16_cnt - d0), 32'd1);
        repeat (2) @(negedge clk);
        check("w_hold16", 32'(w16), 32'(ew));
        check("no_restart16", 32'(busy16), 32'd0);
    endtask

    task automatic run6(input logic [7:0] nn, input logic [5:0] f, input logic [5:0] s,
                        input logic [5:0] ew, input logic eo);
        exp_t e;
        int k;
        @(negedge clk);
        n6 = nn; first6 = f; stride6 = s; start6 = 1'b1;
        e.w = {10'd0, ew}; e.ovf = eo;
        q6.push_back(e);
        @(negedge clk);
        start6 = 1'b0;
        k = 0;
        while (done6 !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("done_latency6", 32'(k), 32'(nn) + 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int k;
        // reset state
        #2 reset_n = 1'b0;
        #1;
        check("rst_w16", 32'(w16), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        check("rst_ovf16", 32'(ovf16), 32'd0);
        check("rst_w6", 32'(w6), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run16(8'd10, 16'd1, 16'd1, 16'd55, 1'b0, 1'b0);
        run16(8'd5, 16'd1, 16'd2, 16'd25, 1'b0, 1'b0);
        run16(8'd4, 16'd100, 16'hFFFF, 16'd394, 1'b1, 1'b0);
        run16(8'd0, 16'd7, 16'd3, 16'd0, 1'b0, 1'b0);
        // single term whose b update carries on the final cycle
        run16(8'd1, 16'hFFFF, 16'd1, 16'hFFFF, 1'b1, 1'b0);
        // maximum term count: 255 terms of 1
        run16(8'd255, 16'd1, 16'd0, 16'd255, 1'b0, 1'b0);
        // start re-asserted while busy and in DONE must be ignored
        run16(8'd10, 16'd1, 16'd1, 16'd55, 1'b0, 1'b1);

        run6(8'd11, 6'd1, 6'd1, 6'd2, 1'b1);
        run6(8'd3, 6'd1, 6'd1, 6'd6, 1'b0);

        // asynchronous reset mid-ACCUM
        @(negedge clk);
        n16 = 8'd200; first16 = 16'd100; stride16 = 16'hFFFF; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy16", 32'(busy16), 32'd1);
        check("pre_rst_ovf16", 32'(ovf16), 32'd1);
        d0 = done16_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_w16", 32'(w16), 32'd0);
        check("mid_rst_busy16", 32'(busy16), 32'd0);
        check("mid_rst_ovf16", 32'(ovf16), 32'd0);
        check("mid_rst_state16", 32'(dut16.state), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
        end
        check("no_done_after_rst16", 32'(done16_cnt - d0), 32'd0);
        check("idle_after_rst16", 32'(busy16), 32'd0);
        run16(8'd3, 16'd1, 16'd1, 16'd6, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("pending16", 32'(q16.size()), 32'd0);
        check("pending6", 32'(q6.size()), 32'd0);
        check("total_done6", 32'(done6_cnt), 32'd2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
